// File: rtl/log_capture_pkg.sv
// ---------------------------------------------------------------------------
// log_capture_pkg
// Shared constants for the log_capture block:
//   - FSM state encoding (ST_IDLE, ST_ARM, ST_POST, ST_DONE)
//   - capture mode constants (MODE_FILL, MODE_TRIG)
//   - is_capturing(): true while the FSM is writing samples (ARM or POST)
// ---------------------------------------------------------------------------
package log_capture_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

  function automatic logic is_capturing(input logic [1:0] st);
    return (st == ST_ARM) || (st == ST_POST);
  endfunction

endpackage

// File: rtl/log_capture_ram.sv
// ---------------------------------------------------------------------------
// log_ram
// Simple dual-port buffer: one synchronous write port, one synchronous read
// port with a registered output (1-cycle read latency).
// Ports:
//   clock, reset            system clock, async active-high reset (read reg only)
//   i_wr_en/i_wr_addr/i_wr_data   write port
//   i_rd_en/i_rd_addr       read request; o_rd_data updates on the next edge
//   o_rd_data               registered read word (reset to 0)
// Storage array is not reset.
// ---------------------------------------------------------------------------
module log_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Output register holds its value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        rd_data_q <= '0;
    else if (i_rd_en) rd_data_q <= mem_q[i_rd_addr];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/log_capture.sv
// ---------------------------------------------------------------------------
// log_capture
// Multi-channel sample logger with fill and pre-triggered capture modes.
// Optional feature macro: LOG_CAPTURE_DECIM_EN (keep 1 of every i_decim+1
// valid samples). Without it every valid sample is accepted.
//
// Ports:
//   clock, reset      system clock, async active-high reset
//   i_valid, i_data   sample stream; channel c at i_data[c*NB +: NB]
//   i_run             capture request level; rising edge in IDLE/DONE starts
//   i_mode            0 = fill, 1 = triggered (sampled at start)
//   i_trig            trigger qualifier (used in ARM only)
//   i_pretrig         pre-trigger sample count (sampled at start)
//   i_decim           decimation factor minus 1 (sampled at start)
//   i_rd_en/i_rd_addr read request, logical offset from capture start
//   o_rd_data/o_rd_valid  read word, valid for exactly one cycle
//   o_busy            FSM in ARM or POST
//   o_full            capture complete
//   o_trig_addr       physical address of the trigger sample
//   o_state           current FSM state (debug)
//
// Handshake: i_valid qualifies i_data for one cycle, there is no
// back-pressure; a read request with i_rd_en produces o_rd_valid exactly one
// cycle later, and only when the FSM is in IDLE or DONE.
// ---------------------------------------------------------------------------
module log_capture
  import log_capture_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int NB      = 8,
  parameter int DEPTH   = 1024,
  parameter int NB_ADDR = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [NCH*NB-1:0]  i_data,
  input  logic               i_run,
  input  logic               i_mode,
  input  logic               i_trig,
  input  logic [NB_ADDR-1:0] i_pretrig,
  input  logic [7:0]         i_decim,
  input  logic               i_rd_en,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NCH*NB-1:0]  o_rd_data,
  output logic               o_rd_valid,
  output logic               o_busy,
  output logic               o_full,
  output logic [NB_ADDR-1:0] o_trig_addr,
  output logic [1:0]         o_state
);

  localparam logic [NB_ADDR:0] DEPTH_W = (NB_ADDR+1)'(DEPTH);
  localparam logic [NB_ADDR:0] ONE_W   = (NB_ADDR+1)'(1);

  logic [1:0]         state_q,     state_d;
  logic               run_q;
  logic [NB_ADDR-1:0] wr_ptr_q,    wr_ptr_d;
  logic [NB_ADDR-1:0] pre_cnt_q,   pre_cnt_d;
  logic [NB_ADDR:0]   post_cnt_q,  post_cnt_d;
  logic [NB_ADDR-1:0] start_q,     start_d;
  logic [NB_ADDR-1:0] trig_addr_q, trig_addr_d;
  logic               full_q,      full_d;
  logic               mode_q,      mode_d;
  logic [NB_ADDR-1:0] p_q,         p_d;
  logic               rd_valid_q;

  logic               run_rise;
  logic               accept;
  logic               wr_en;
  logic               rd_fire;
  logic [NB_ADDR:0]   pre_inc;
  logic               trig_ok;
  logic [NB_ADDR:0]   target;
  logic [NB_ADDR:0]   post_inc;

  assign run_rise = i_run & ~run_q;
  assign rd_fire  = i_rd_en & ~is_capturing(state_q);

  // -------------------------------------------------------------------------
  // Sample acceptance (optional decimation)
  // -------------------------------------------------------------------------
`ifdef LOG_CAPTURE_DECIM_EN
  logic [7:0] decim_q, decim_d;
  logic [7:0] dec_cnt_q, dec_cnt_d;

  assign accept = is_capturing(state_q) & i_run & i_valid & (dec_cnt_q == 8'd0);

  always_comb begin
    decim_d   = decim_q;
    dec_cnt_d = dec_cnt_q;
    if (run_rise && !is_capturing(state_q)) begin
      decim_d   = i_decim;
      dec_cnt_d = 8'd0;
    end else if (is_capturing(state_q) && i_run && i_valid) begin
      dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decim_q   <= 8'd0;
      dec_cnt_q <= 8'd0;
    end else begin
      decim_q   <= decim_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end
`else
  logic unused_decim;
  assign unused_decim = ^i_decim;
  assign accept = is_capturing(state_q) & i_run & i_valid;
`endif

  // Pre-count after the current sample; the sample that brings it up to P
  // is itself allowed to be the trigger.
  assign pre_inc  = {1'b0, pre_cnt_q} + ONE_W;
  assign trig_ok  = (pre_inc >= {1'b0, p_q});
  assign post_inc = post_cnt_q + ONE_W;
  // Samples to store after the trigger (trigger included), or whole buffer.
  assign target   = (mode_q == MODE_TRIG) ? (DEPTH_W - {1'b0, p_q}) : DEPTH_W;

  // -------------------------------------------------------------------------
  // Capture FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    start_d     = start_q;
    trig_addr_d = trig_addr_q;
    full_d      = full_q;
    mode_d      = mode_q;
    p_d         = p_q;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_rise) begin
          wr_ptr_d   = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          start_d    = '0;
          full_d     = 1'b0;
          mode_d     = i_mode;
          // i_pretrig cannot exceed DEPTH-1 by width, so min() is implicit.
          p_d        = i_pretrig;
          state_d    = (i_mode == MODE_TRIG) ? ST_ARM : ST_POST;
        end
      end

      ST_ARM: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + NB_ADDR'(1);
          pre_cnt_d = trig_ok ? p_q : pre_inc[NB_ADDR-1:0];
          if (trig_ok && i_trig) begin
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = ONE_W;
            if (target == ONE_W) begin
              // P = DEPTH-1: the trigger sample completes the buffer.
              state_d = ST_DONE;
              full_d  = 1'b1;
              start_d = wr_ptr_q - p_q;
            end else begin
              state_d = ST_POST;
            end
          end
        end
      end

      ST_POST: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + NB_ADDR'(1);
          post_cnt_d = post_inc;
          if (post_inc == target) begin
            state_d = ST_DONE;
            full_d  = 1'b1;
            start_d = (mode_q == MODE_TRIG) ? (trig_addr_q - p_q) : '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      start_q     <= '0;
      trig_addr_q <= '0;
      full_q      <= 1'b0;
      mode_q      <= MODE_FILL;
      p_q         <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= i_run;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      start_q     <= start_d;
      trig_addr_q <= trig_addr_d;
      full_q      <= full_d;
      mode_q      <= mode_d;
      p_q         <= p_d;
      rd_valid_q  <= rd_fire;
    end
  end

  // -------------------------------------------------------------------------
  // Buffer
  // -------------------------------------------------------------------------
  log_ram #(
    .W     (NCH*NB),
    .DEPTH (DEPTH),
    .AW    (NB_ADDR)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data),
    .i_rd_en   (rd_fire),
    .i_rd_addr (start_q + i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  assign o_rd_valid  = rd_valid_q;
  assign o_busy      = is_capturing(state_q);
  assign o_full      = full_q;
  assign o_trig_addr = trig_addr_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_log_capture.sv
// ---------------------------------------------------------------------------
// tb_log_capture
// Directed bench for log_capture with NCH=2, NB=8, DEPTH=16. i_data carries
// the sample index counted from the first cycle after the run rising edge.
// ---------------------------------------------------------------------------
module tb_log_capture;

  localparam int NCH = 2;
  localparam int NB  = 8;
  localparam int DEPTH = 16;
  localparam int AW  = 4;

  logic              clock;
  logic              reset;
  logic              i_valid;
  logic [NCH*NB-1:0] i_data;
  logic              i_run;
  logic              i_mode;
  logic              i_trig;
  logic [AW-1:0]     i_pretrig;
  logic [7:0]        i_decim;
  logic              i_rd_en;
  logic [AW-1:0]     i_rd_addr;
  logic [NCH*NB-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic              o_full;
  logic [AW-1:0]     o_trig_addr;
  logic [1:0]        o_state;

  int n_vec = 0;
  int n_err = 0;
  int last_k;

  log_capture #(.NCH(NCH), .NB(NB), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_run       (i_run),
    .i_mode      (i_mode),
    .i_trig      (i_trig),
    .i_pretrig   (i_pretrig),
    .i_decim     (i_decim),
    .i_rd_en     (i_rd_en),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_busy      (o_busy),
    .o_full      (o_full),
    .o_trig_addr (o_trig_addr),
    .o_state     (o_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drivers (called at a negedge, return at a negedge)
  task automatic run_capture(input logic mode, input logic [AW-1:0] pre,
                             input logic [7:0] dec, input int ta, input int tb,
                             output int done_k);
    i_run  = 1'b0;
    i_trig = 1'b0;
    @(negedge clock);
    i_mode    = mode;
    i_pretrig = pre;
    i_decim   = dec;
    i_run     = 1'b1;
    i_valid   = 1'b1;
    i_data    = '0;
    @(negedge clock);
    // Configuration must be held from the start edge.
    i_mode    = ~mode;
    i_pretrig = ~pre;
    i_decim   = ~dec;
    done_k = -1;
    for (int k = 0; k < 200; k++) begin
      i_data = 16'(k);
      i_trig = (k == ta) || (k == tb);
      @(negedge clock);
      if (o_full) begin
        done_k = k;
        break;
      end
    end
    i_trig = 1'b0;
    check_eq("cap_full", o_full, 1);
    check_eq("cap_busy", o_busy, 0);
    check_eq("cap_state", o_state, 3);
  endtask

  task automatic read_chk(input string tag, input int a, input logic [15:0] exp);
    i_rd_en   = 1'b1;
    i_rd_addr = 4'(a);
    @(negedge clock);
    i_rd_en = 1'b0;
    check_eq({tag, "_v"}, o_rd_valid, 1);
    check_eq(tag, o_rd_data, exp);
  endtask

  task automatic valid_drop_chk(input string tag);
    @(negedge clock);
    check_eq(tag, o_rd_valid, 0);
  endtask

  // Stimulus + checks
  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_run = 1'b0; i_mode = 1'b0;
    i_trig = 1'b0; i_pretrig = '0; i_decim = '0; i_rd_en = 1'b0; i_rd_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_full", o_full, 0);
    check_eq("rst_rd_valid", o_rd_valid, 0);
    check_eq("rst_rd_data", o_rd_data, 0);
    check_eq("rst_trig_addr", o_trig_addr, 0);
    check_eq("rst_state", o_state, 0);

    // Fill mode: 16 samples, addr a returns a
    run_capture(1'b0, 4'd0, 8'd0, -1, -1, last_k);
    check_eq("fill_len", last_k, 15);
    for (int a = 0; a < 16; a++) read_chk("fill_rd", a, 16'(a));
    valid_drop_chk("fill_rd_drop");
    // Dropping i_run in DONE keeps the capture
    i_run = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("done_hold_full", o_full, 1);
    read_chk("done_hold_rd", 7, 16'd7);

    // Triggered, P=4, trigger on sample 10: trig addr 10, start 6
    run_capture(1'b1, 4'd4, 8'd0, 10, -1, last_k);
    check_eq("trig10_len", last_k, 21);
    check_eq("trig10_addr", o_trig_addr, 10);
    for (int a = 0; a < 16; a++) read_chk("trig10_rd", a, 16'(6 + a));

    // Triggered, P=4, early trigger on 2 ignored, trigger on 20 accepted
    run_capture(1'b1, 4'd4, 8'd0, 2, 20, last_k);
    check_eq("trig20_len", last_k, 31);
    check_eq("trig20_addr", o_trig_addr, 4);
    read_chk("trig20_rd0", 0, 16'd16);
    read_chk("trig20_rd5", 5, 16'd21);
    read_chk("trig20_rd15", 15, 16'd31);

    // Abort: i_run dropped at sample 5 of POST; reads blocked while busy
    i_run = 1'b0;
    @(negedge clock);
    i_mode = 1'b0; i_run = 1'b1; i_data = '0;
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      i_data  = 16'(k);
      i_rd_en = (k == 2);
      @(negedge clock);
      if (k == 2) check_eq("busy_rd_ignored", o_rd_valid, 0);
    end
    i_rd_en = 1'b0;
    check_eq("abort_pre_busy", o_busy, 1);
    check_eq("abort_pre_full", o_full, 0);
    i_run  = 1'b0;
    i_data = 16'd5;
    @(negedge clock);
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_full", o_full, 0);
    check_eq("abort_state", o_state, 0);
    i_rd_en = 1'b1; i_rd_addr = 4'd3;
    @(negedge clock);
    i_rd_en = 1'b0;
    check_eq("abort_rd_v", o_rd_valid, 1);
    valid_drop_chk("abort_rd_drop");

    // Decimation factor 3
    run_capture(1'b0, 4'd0, 8'd2, -1, -1, last_k);
`ifdef LOG_CAPTURE_DECIM_EN
    check_eq("decim_len", last_k, 45);
    for (int a = 0; a < 16; a++) read_chk("decim_rd", a, 16'(3 * a));
`else
    check_eq("decim_len", last_k, 15);
    for (int a = 0; a < 16; a++) read_chk("decim_rd", a, 16'(a));
`endif

    // Reset mid-POST: outputs clear without a clock edge
    i_run = 1'b0;
    @(negedge clock);
    i_mode = 1'b0; i_run = 1'b1; i_data = '0;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      i_data = 16'(k);
      @(negedge clock);
    end
    check_eq("mid_busy", o_busy, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_busy", o_busy, 0);
    check_eq("arst_full", o_full, 0);
    check_eq("arst_rd_valid", o_rd_valid, 0);
    check_eq("arst_rd_data", o_rd_data, 0);
    check_eq("arst_trig_addr", o_trig_addr, 0);
    check_eq("arst_state", o_state, 0);
    i_run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_capture(1'b0, 4'd0, 8'd0, -1, -1, last_k);
    check_eq("post_rst_len", last_k, 15);
    read_chk("post_rst_rd0", 0, 16'd0);
    read_chk("post_rst_rd9", 9, 16'd9);
    read_chk("post_rst_rd15", 15, 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/log_capture.md
LOG_CAPTURE -- requirements
Module: log_capture

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of sample channels.
REQ-002 SHALL have parameter NB, default 8, meaning bits per channel sample.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning buffer words (power of 2).
REQ-004 SHALL have parameter NB_ADDR, default clog2(DEPTH), meaning address width.
REQ-005 SHALL have port clock, input, 1, meaning the single system clock.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1, meaning a sample is present on i_data.
REQ-008 SHALL have port i_data, input, NCH*NB, meaning channel c at bits [c*NB +: NB].
REQ-009 SHALL have port i_run, input, 1, meaning capture request (level; rising edge starts).
REQ-010 SHALL have port i_mode, input, 1, meaning 0 = fill, 1 = triggered.
REQ-011 SHALL have port i_trig, input, 1, meaning trigger qualifier.
REQ-012 SHALL have port i_pretrig, input, NB_ADDR, meaning pre-trigger sample count.
REQ-013 SHALL have port i_decim, input, 8, meaning decimation factor minus 1.
REQ-014 SHALL have port i_rd_en, input, 1, meaning read request.
REQ-015 SHALL have port i_rd_addr, input, NB_ADDR, meaning logical read offset from capture start.
REQ-016 SHALL have port o_rd_data, output, NCH*NB, meaning read word.
REQ-017 SHALL have port o_rd_valid, output, 1, meaning o_rd_data is valid.
REQ-018 SHALL have port o_busy, output, 1, meaning state is ARM or POST.
REQ-019 SHALL have port o_full, output, 1, meaning capture is complete.
REQ-020 SHALL have port o_trig_addr, output, NB_ADDR, meaning physical address of the trigger sample.

Function
REQ-021 SHALL implement FSM IDLE, ARM, POST, DONE.
REQ-022 SHALL accept a sample only when i_valid=1 and the decimation counter is 0; each accepted sample is written at wr_ptr, and wr_ptr then increments modulo DEPTH.
REQ-023 SHALL, on an i_run rising edge in IDLE or DONE: clear wr_ptr and the counters, clear o_full, and go to POST if i_mode=0 or to ARM if i_mode=1.
REQ-024 SHALL, in POST with i_mode=0, store DEPTH samples, set start=0, then go to DONE.
REQ-025 SHALL, in ARM, write as a ring and saturate the pre-count at P = min(i_pretrig, DEPTH-1).
REQ-026 SHALL, in ARM, accept i_trig only on an accepted sample when pre-count ≥ P; this includes the sample that makes pre-count reach P.
REQ-027 SHALL ignore i_trig in ARM before pre-count reaches P.
REQ-028 SHALL, on trigger acceptance, latch o_trig_addr = wr_ptr of the trigger sample.
REQ-029 SHALL, after trigger acceptance, store DEPTH−P samples including the trigger sample, then go to DONE with start = (o_trig_addr − P) mod DEPTH.
REQ-030 SHALL set o_full=1 on entry to DONE and hold it until the next start or reset.
REQ-031 SHALL, on i_run=0 in ARM or POST, abort to IDLE on the next cycle with o_full=0; buffer contents are undefined after an abort.
REQ-032 SHALL, on i_run=0 in DONE, remain in DONE with data retained.
REQ-033 SHALL, on i_rd_en in IDLE or DONE, read physical address (start + i_rd_addr) mod DEPTH with 1-cycle latency, and assert o_rd_valid for exactly 1 cycle.
REQ-034 SHALL ignore i_rd_en while o_busy=1; o_rd_valid stays 0.
REQ-035 SHALL sample i_mode, i_pretrig and i_decim only at start and hold them for the capture.

Reset
REQ-036 SHALL, on reset, go to IDLE and zero wr_ptr, counters, start, o_trig_addr, o_rd_data, o_rd_valid, o_busy and o_full; RAM contents are not reset.

Configuration
REQ-037 SHALL, with LOG_CAPTURE_DECIM_EN defined, accept 1 of every i_decim+1 valid samples, with the counter restarting at start.
REQ-038 SHALL, without LOG_CAPTURE_DECIM_EN, ignore i_decim and accept every valid sample.

Structure
REQ-039 SHALL place the state encoding and the mode constants (MODE_FILL=0, MODE_TRIG=1) in package log_capture_pkg.
REQ-040 SHALL instantiate a single sub-module log_ram (simple dual-port, synchronous write and read, NCH*NB × DEPTH).

Verification (NCH=2, NB=8, DEPTH=16, i_data = sample index, i_valid=1 continuous)
REQ-041 SHALL cover: mode 0, run rise -> o_full after 16 samples; reading addr 0..15 returns 0..15 one cycle after i_rd_en.
REQ-042 SHALL cover: mode 1, pretrig=4, trig on sample 10 -> o_trig_addr=10, start=6; reading addr 0..15 returns 6..21.
REQ-043 SHALL cover: mode 1, pretrig=4, trig on sample 2 ignored and trig on sample 20 accepted -> o_trig_addr=4; addr 0 returns 16, addr 15 returns 31.
REQ-044 SHALL cover: i_run dropped at sample 5 of POST -> IDLE next cycle, o_busy=0, o_full=0, and reads are honoured again.
REQ-045 SHALL cover: with the macro, i_decim=2 -> stored 0,3,6,...; without the macro -> stored 0,1,2,....
REQ-046 SHALL cover: reset asserted mid-POST -> all outputs 0 asynchronously; a subsequent run rise performs a full capture.
